mc_datapath: RTL and testbench
==============================

// Module: mc_datapath
// PURPOSE
//  Parametrised multi-cycle MIPS datapath, successor to the single-cycle datapath.
//  Holds PC, IR, MDR, A, B and ALUOut, plus a register file and the ALU.
//  An external multi-cycle controller sequences it through IF/ID/EX/MEM/WB over 3-5 clocks.
//  Adds conditional PC write (beq/bne), jr/jal support and a single shared memory port.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset
//  NREGS     32             register-file depth, power of two, 8..32; rs/rt/rd >= NREGS read 0, writes dropped
//  PC_STEP   4              constant selected by ALUSrcB=01 (PC increment)
// PORTS
//  clk          in   1   clock, all state updates on posedge
//  rst          in   1   asynchronous active-high reset
//  PCWrite      in   1   unconditional PC load
//  PCWriteCond  in   1   PC load gated by branch condition
//  BranchNE     in   1   0: branch when zero=1 (beq); 1: branch when zero=0 (bne)
//  IorD         in   1   memory address select: 0 PC, 1 ALUOut
//  IRWrite      in   1   load IR from Data_in
//  RegDst       in   2   write reg select: 00 rt, 01 rd, 10 $31 (link), 11 rt
//  MemtoReg     in   1   write data select: 0 ALUOut, 1 MDR (ignored when RegDst=10)
//  RegWrite     in   1   register-file write enable
//  ALUSrcA      in   1   ALU A select: 0 PC, 1 A reg
//  ALUSrcB      in   2   ALU B select: 00 B reg, 01 PC_STEP, 10 sext(imm), 11 sext(imm)<<2
//  PCSource     in   2   next PC: 00 ALU result, 01 ALUOut, 10 {PC[31:28],IR[25:0],2'b00}, 11 A reg
//  ALU_Control  in   3   000 and, 001 or, 010 add, 011 xor, 100 nor, 101 srl, 110 sub, 111 slt
//  Data_in      in   32  memory read data
//  M_addr       out  32  memory address
//  Data_out     out  32  memory write data (= B reg)
//  PC_out       out  32  current PC
//  Inst_out     out  32  current IR, fed to the controller
//  zero         out  1   ALU result == 0 (combinational)
//  overflow     out  1   signed overflow of add/sub (combinational), 0 for other ops
// BEHAVIOUR
//  Reset: PC=RESET_PC; IR, MDR, A, B, ALUOut and all registers = 0. Reset mid-instruction
//   abandons it; first post-reset cycle is whatever the controller drives (expected IF).
//  MDR <= Data_in, A <= R[IR[25:21]], B <= R[IR[20:16]], ALUOut <= ALU result: every posedge.
//  IR <= Data_in only when IRWrite=1; otherwise holds.
//  PC loads when PCWrite | (PCWriteCond & (zero ^ BranchNE)); else holds.
//  PCWrite and PCWriteCond both high: PCWrite wins (unconditional load).
//  Reg file: 2 async read ports, 1 sync write port. Write to $0 ignored; $0 always reads 0.
//   Read and write of the same register in one cycle: A/B capture the OLD value (no bypass).
//  Link: RegDst=10 writes current PC (already incremented by IF) into $31.
//  ALU: 32-bit, wraps modulo 2^32. slt signed, result 0/1. srl: B >> A[4:0], logical.
//   sub = A + ~B + 1; overflow = operand signs equal (add) / differ (sub) and result sign differs.
//  sext(imm) = {{16{IR[15]}}, IR[15:0]}.
//  M_addr = IorD ? ALUOut : PC; no alignment checking, low two bits passed through.
//  Latency: register updates visible the cycle after the enabling edge; outputs never X after reset.
// TESTING
//  1 Reset with RESET_PC=32'h0000_0040 -> PC_out=0x40, Inst_out=0, all registers read 0.
//  2 IF: IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALU_Control=010, PCSource=00, PCWrite=1,
//    Data_in=0x2008_0005 -> IR=0x20080005, PC 0x40->0x44; then addi EX/WB -> $8=5.
//  3 beq with $8=$9=5, imm=0x0003, PCWriteCond=1, BranchNE=0 -> PC=PC+4+12; repeat
//    with BranchNE=1 -> PC unchanged.
//  4 ALU: add 0x7FFF_FFFF+1 -> 0x8000_0000, overflow=1; slt -1,1 -> 1; srl 0x8000_0000 by 31 -> 1.
//  5 jal from PC=0x0040_0008 (after IF), IR[25:0]=0x10 -> $31=0x0040_0008, PC=0x0000_0040;
//    jr via PCSource=11 with A=$31 -> PC=0x0040_0008.
//  6 RegWrite to $0 with 0xDEAD_BEEF -> $0 reads 0; assert rst mid-EX -> all state back to reset values.

Source files
------------

// File: rtl/mc_datapath.sv
// mc_datapath: multi-cycle MIPS datapath holding PC, IR, MDR, A, B, ALUOut, a register file and the ALU,
// sequenced externally through IF/ID/EX/MEM/WB.
module mc_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWrite,
  input  logic        PCWriteCond,
  input  logic        BranchNE,
  input  logic        IorD,
  input  logic        IRWrite,
  input  logic [1:0]  RegDst,
  input  logic        MemtoReg,
  input  logic        RegWrite,
  input  logic        ALUSrcA,
  input  logic [1:0]  ALUSrcB,
  input  logic [1:0]  PCSource,
  input  logic [2:0]  ALU_Control,
  input  logic [31:0] Data_in,
  output logic [31:0] M_addr,
  output logic [31:0] Data_out,
  output logic [31:0] PC_out,
  output logic [31:0] Inst_out,
  output logic        zero,
  output logic        overflow
);
  localparam int        AW = $clog2(NREGS);
  localparam logic [5:0] NR = 6'(NREGS);
  logic [31:0] r_pc, r_ir, r_mdr, r_a, r_b, r_alu_out;
  logic [31:0] r_rf [NREGS];
  logic [4:0]  w_rs, w_rt, w_dst;
  logic [31:0] w_rd_a, w_rd_b, w_wd, w_sext, w_src_a, w_src_b, w_bx, w_sum, w_res, w_pc_next;
  logic        w_sub, w_we, w_pc_ld;
  assign w_rs = r_ir[25:21];
  assign w_rt = r_ir[20:16];
  // Indices beyond the implemented depth read as zero and never write.
  assign w_rd_a = (w_rs != 5'd0 && {1'b0, w_rs} < NR) ? r_rf[w_rs[AW-1:0]] : '0;
  assign w_rd_b = (w_rt != 5'd0 && {1'b0, w_rt} < NR) ? r_rf[w_rt[AW-1:0]] : '0;
  assign w_dst = RegDst == 2'b01 ? r_ir[15:11] : RegDst == 2'b10 ? 5'd31 : w_rt;
  assign w_we = RegWrite && w_dst != 5'd0 && {1'b0, w_dst} < NR;
  assign w_wd = RegDst == 2'b10 ? r_pc : MemtoReg ? r_mdr : r_alu_out;
  assign w_sext = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_src_a = ALUSrcA ? r_a : r_pc;
  assign w_src_b = ALUSrcB == 2'b00 ? r_b : ALUSrcB == 2'b01 ? PC_STEP :
                   ALUSrcB == 2'b10 ? w_sext : {w_sext[29:0], 2'b00};
  assign w_sub = ALU_Control == 3'b110;
  assign w_bx = w_sub ? ~w_src_b : w_src_b;
  assign w_sum = w_src_a + w_bx + {31'b0, w_sub};
  always_comb begin
    w_res = '0;
    case (ALU_Control)
      3'b000: w_res = w_src_a & w_src_b;
      3'b001: w_res = w_src_a | w_src_b;
      3'b011: w_res = w_src_a ^ w_src_b;
      3'b100: w_res = ~(w_src_a | w_src_b);
      3'b101: w_res = w_src_b >> w_src_a[4:0];
      3'b111: w_res = {31'b0, $signed(w_src_a) < $signed(w_src_b)};
      default: w_res = w_sum;
    endcase
  end
  assign zero = w_res == '0;
  assign overflow = (ALU_Control == 3'b010 || w_sub) && w_src_a[31] == w_bx[31] && w_sum[31] != w_src_a[31];
  assign w_pc_next = PCSource == 2'b00 ? w_res : PCSource == 2'b01 ? r_alu_out :
                     PCSource == 2'b10 ? {r_pc[31:28], r_ir[25:0], 2'b00} : r_a;
  assign w_pc_ld = PCWrite || (PCWriteCond && (zero ^ BranchNE));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
      r_ir <= '0;
      r_mdr <= '0;
      r_a <= '0;
      r_b <= '0;
      r_alu_out <= '0;
    end else begin
      if (w_pc_ld) r_pc <= w_pc_next;
      if (IRWrite) r_ir <= Data_in;
      r_mdr <= Data_in;
      r_a <= w_rd_a;
      r_b <= w_rd_b;
      r_alu_out <= w_res;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
    end else if (w_we) begin
      r_rf[w_dst[AW-1:0]] <= w_wd;
    end
  end
  assign M_addr = IorD ? r_alu_out : r_pc;
  assign Data_out = r_b;
  assign PC_out = r_pc;
  assign Inst_out = r_ir;
endmodule

// File: tb/tb_mc_datapath.sv
// tb_mc_datapath: directed and random checks of mc_datapath against an architectural reference model.
module tb_mc_datapath;
  logic clk = 1'b0, rst = 1'b1;
  logic PCWrite, PCWriteCond, BranchNE, IorD, IRWrite, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] RegDst, ALUSrcB, PCSource;
  logic [2:0] ALU_Control;
  logic [31:0] Data_in, M_addr, Data_out, PC_out, Inst_out;
  logic zero, overflow, obs_ov;
  logic [31:0] m_pc, m_ir, m_mdr, m_a, m_b, m_alu_out;
  logic [31:0] m_r [32];
  int n_chk = 0, n_pass = 0;

  mc_datapath #(.RESET_PC(32'h0000_0040), .NREGS(32), .PC_STEP(32'd4)) dut (
    .clk(clk), .rst(rst), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNE(BranchNE),
    .IorD(IorD), .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALU_Control(ALU_Control),
    .Data_in(Data_in), .M_addr(M_addr), .Data_out(Data_out), .PC_out(PC_out),
    .Inst_out(Inst_out), .zero(zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a + b;
      3'd3: return a ^ b;
      3'd4: return ~(a | b);
      3'd5: return b >> a[4:0];
      3'd6: return a - b;
      default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  function automatic logic ovf_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint s;
    if (op != 3'd2 && op != 3'd6) return 1'b0;
    s = op == 3'd2 ? longint'($signed(a)) + longint'($signed(b)) : longint'($signed(a)) - longint'($signed(b));
    return s > 64'sd2147483647 || s < -64'sd2147483648;
  endfunction

  task automatic model_reset();
    m_pc = 32'h40; m_ir = 0; m_mdr = 0; m_a = 0; m_b = 0; m_alu_out = 0;
    for (int i = 0; i < 32; i++) m_r[i] = 0;
  endtask

  task automatic drive(input logic pcw, input logic pcwc, input logic bne, input logic iord, input logic irw,
                       input logic [1:0] rd, input logic m2r, input logic rw, input logic sa,
                       input logic [1:0] sb, input logic [1:0] ps, input logic [2:0] op, input logic [31:0] din);
    PCWrite = pcw; PCWriteCond = pcwc; BranchNE = bne; IorD = iord; IRWrite = irw; RegDst = rd;
    MemtoReg = m2r; RegWrite = rw; ALUSrcA = sa; ALUSrcB = sb; PCSource = ps; ALU_Control = op; Data_in = din;
  endtask

  // One clock: predict outputs from the architectural state, check them mid-cycle, then advance the model.
  task automatic cyc();
    logic [31:0] a, b, sx, res, nxt, wd, na, nb;
    logic ov, z, ld;
    logic [4:0] dst;
    sx = {{16{m_ir[15]}}, m_ir[15:0]};
    a = ALUSrcA ? m_a : m_pc;
    b = ALUSrcB == 0 ? m_b : ALUSrcB == 1 ? 32'd4 : ALUSrcB == 2 ? sx : sx * 4;
    res = alu_f(ALU_Control, a, b);
    ov = ovf_f(ALU_Control, a, b);
    z = res == 0;
    @(negedge clk);
    obs_ov = overflow;
    chk("pc", PC_out, m_pc);
    chk("ir", Inst_out, m_ir);
    chk("dout", Data_out, m_b);
    chk("addr", M_addr, IorD ? m_alu_out : m_pc);
    chk("zero", {31'b0, zero}, {31'b0, z});
    chk("ovf", {31'b0, overflow}, {31'b0, ov});
    @(posedge clk);
    ld = PCWrite || (PCWriteCond && (BranchNE ? !z : z));
    nxt = PCSource == 0 ? res : PCSource == 1 ? m_alu_out : PCSource == 2 ? {m_pc[31:28], m_ir[25:0], 2'b00} : m_a;
    na = m_r[m_ir[25:21]];
    nb = m_r[m_ir[20:16]];
    dst = RegDst == 1 ? m_ir[15:11] : RegDst == 2 ? 5'd31 : m_ir[20:16];
    wd = RegDst == 2 ? m_pc : MemtoReg ? m_mdr : m_alu_out;
    if (RegWrite && dst != 0) m_r[dst] = wd;
    if (ld) m_pc = nxt;
    if (IRWrite) m_ir = Data_in;
    m_mdr = Data_in; m_a = na; m_b = nb; m_alu_out = res;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 2'd0, 3'd0, 32'd0);
    cyc();
  endtask

  task automatic set_ir(input logic [31:0] w);
    drive(0, 0, 0, 0, 1, 2'd0, 0, 0, 0, 2'd0, 2'd0, 3'd0, w);
    cyc();
    idle();
  endtask

  task automatic load_reg(input logic [4:0] r, input logic [31:0] val);
    drive(0, 0, 0, 0, 1, 2'd0, 0, 0, 0, 2'd0, 2'd0, 3'd0, {6'h23, 5'd0, r, 16'h0});
    cyc();
    drive(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 2'd0, 3'd0, val);
    cyc();
    drive(0, 0, 0, 0, 0, 2'd0, 1, 1, 0, 2'd0, 2'd0, 3'd0, 32'd0);
    cyc();
  endtask

  task automatic fetch(input logic [31:0] w);
    drive(1, 0, 0, 0, 1, 2'd0, 0, 0, 0, 2'd1, 2'd0, 3'd2, w);
    cyc();
  endtask

  task automatic addi_seq(input logic [31:0] w);
    fetch(w);
    idle();
    drive(0, 0, 0, 0, 0, 2'd0, 0, 0, 1, 2'd2, 2'd0, 3'd2, 32'd0);
    cyc();
    drive(0, 0, 0, 0, 0, 2'd0, 0, 1, 0, 2'd0, 2'd0, 3'd0, 32'd0);
    cyc();
  endtask

  task automatic alu_ex(input logic [2:0] op);
    set_ir({6'h0, 5'd10, 5'd11, 16'h0});
    drive(0, 0, 0, 1, 0, 2'd0, 0, 0, 1, 2'd0, 2'd0, op, 32'd0);
    cyc();
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 2'd0, 3'd0, 32'd0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk("rst_pc", PC_out, 32'h40);
    chk("rst_ir", Inst_out, 32'h0);
    rst = 1'b0;
    fetch(32'h2008_0005);
    chk("if_ir", Inst_out, 32'h2008_0005);
    chk("if_pc", PC_out, 32'h44);
    drive(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd1, 2'd0, 3'd2, 32'd0);
    idle();
    drive(0, 0, 0, 0, 0, 2'd0, 0, 0, 1, 2'd2, 2'd0, 3'd2, 32'd0);
    cyc();
    drive(0, 0, 0, 0, 0, 2'd0, 0, 1, 0, 2'd0, 2'd0, 3'd0, 32'd0);
    cyc();
    addi_seq(32'h2009_0005);
    fetch(32'h1109_0003);
    drive(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd3, 2'd0, 3'd2, 32'd0);
    cyc();
    chk("beq_b", Data_out, 32'd5);
    drive(0, 1, 0, 0, 0, 2'd0, 0, 0, 1, 2'd0, 2'd1, 3'd6, 32'd0);
    cyc();
    chk("beq_taken", PC_out, 32'h58);
    drive(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd3, 2'd0, 3'd2, 32'd0);
    cyc();
    drive(0, 1, 1, 0, 0, 2'd0, 0, 0, 1, 2'd0, 2'd1, 3'd6, 32'd0);
    cyc();
    chk("bne_not_taken", PC_out, 32'h58);
    load_reg(10, 32'h7FFF_FFFF);
    load_reg(11, 32'd1);
    alu_ex(3'd2);
    chk("add_ovf", {31'b0, obs_ov}, 32'd1);
    chk("add_res", M_addr, 32'h8000_0000);
    load_reg(10, 32'hFFFF_FFFF);
    alu_ex(3'd7);
    chk("slt_res", M_addr, 32'd1);
    load_reg(10, 32'd31);
    load_reg(11, 32'h8000_0000);
    alu_ex(3'd5);
    chk("srl_res", M_addr, 32'd1);
    load_reg(12, 32'h0040_0004);
    set_ir({6'h0, 5'd12, 21'h0});
    drive(1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 2'd3, 3'd0, 32'd0);
    cyc();
    fetch(32'h0C00_0010);
    chk("jal_if_pc", PC_out, 32'h0040_0008);
    drive(1, 0, 0, 0, 0, 2'd2, 0, 1, 0, 2'd0, 2'd2, 3'd0, 32'd0);
    cyc();
    chk("jal_pc", PC_out, 32'h40);
    set_ir({6'h0, 5'd31, 5'd31, 16'h8});
    chk("jal_link", Data_out, 32'h0040_0008);
    drive(1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 2'd3, 3'd0, 32'd0);
    cyc();
    chk("jr_pc", PC_out, 32'h0040_0008);
    load_reg(0, 32'hDEAD_BEEF);
    set_ir(32'h0);
    chk("r0_b", Data_out, 32'h0);
    drive(0, 0, 0, 1, 0, 2'd0, 0, 0, 1, 2'd1, 2'd0, 3'd2, 32'd0);
    cyc();
    chk("r0_a", M_addr, 32'd4);
    set_ir({6'h0, 5'd31, 5'd10, 16'h0});
    drive(0, 0, 0, 0, 0, 2'd0, 0, 1, 1, 2'd2, 2'd0, 3'd2, 32'd0);
    #3 rst = 1'b1;
    #1 model_reset();
    chk("mid_rst_pc", PC_out, 32'h40);
    chk("mid_rst_ir", Inst_out, 32'h0);
    chk("mid_rst_b", Data_out, 32'h0);
    chk("mid_rst_addr", M_addr, 32'h40);
    @(posedge clk); #1 rst = 1'b0;
    set_ir({6'h0, 5'd31, 5'd10, 16'h0});
    chk("post_rst_b", Data_out, 32'h0);
    repeat (600) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom), 3'($urandom), $urandom);
      cyc();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
